// File: rtl/dsp_post_acc_if.sv
// dsp_post_acc_if -- operand/result bundle for the DSP post-adder/accumulator.
//   master : drives operands (m_in, c_in, pcin, x_sel, z_sel, sub, cin, in_vld, en_p)
//            and observes results (p, pcout, carryout, p_vld, ovf)
//   slave  : the accumulator itself
interface dsp_post_acc_if #(
  parameter int PW = 48,
  parameter int MW = 36
);
  logic [MW-1:0] m_in;
  logic [PW-1:0] c_in;
  logic [PW-1:0] pcin;
  logic          x_sel;
  logic [1:0]    z_sel;
  logic          sub;
  logic          cin;
  logic          in_vld;
  logic          en_p;
  logic [PW-1:0] p;
  logic [PW-1:0] pcout;
  logic          carryout;
  logic          p_vld;
  logic          ovf;

  modport master (
    output m_in, c_in, pcin, x_sel, z_sel, sub, cin, in_vld, en_p,
    input  p, pcout, carryout, p_vld, ovf
  );

  modport slave (
    input  m_in, c_in, pcin, x_sel, z_sel, sub, cin, in_vld, en_p,
    output p, pcout, carryout, p_vld, ovf
  );
endinterface

// File: rtl/dsp_post_acc.sv
// dsp_post_acc -- DSP post-adder / accumulator (X/Z mux, add/sub with carry, P register).
//   clk  : rising-edge clock
//   rstn : asynchronous reset, active HIGH despite the name (clears all state)
//   bus  : dsp_post_acc_if.slave -- operands in, P/carry/valid/overflow out
// Parameters: PW (P width), MW (product width, < PW), REG_IN (1 = operand register stage).
// Optional feature: define DSP_SAT_EN to saturate P on signed overflow and latch ovf;
// otherwise P wraps modulo 2^PW and ovf is tied low.
module dsp_post_acc #(
  parameter int PW     = 48,
  parameter int MW     = 36,
  parameter int REG_IN = 1
) (
  input logic           clk,
  input logic           rstn,
  dsp_post_acc_if.slave bus
);

  typedef struct packed {
    logic [MW-1:0] m;
    logic [PW-1:0] c;
    logic [PW-1:0] pc;
    logic          xs;
    logic [1:0]    zs;
    logic          sb;
    logic          ci;
    logic          vld;
  } op_t;

  op_t           in_w, s1;
  logic [PW-1:0] p_q, x, z, p_nxt;
  logic [PW:0]   r;
  logic          co_q, vld_q;

  assign in_w = '{m: bus.m_in, c: bus.c_in, pc: bus.pcin, xs: bus.x_sel, zs: bus.z_sel,
                  sb: bus.sub, ci: bus.cin, vld: bus.in_vld};

  // stage 1: optional operand register, shares the P clock enable
  generate
    if (REG_IN != 0) begin : g_reg_in
      always_ff @(posedge clk or posedge rstn) begin
        if (rstn)          s1 <= '0;
        else if (bus.en_p) s1 <= in_w;
      end
    end else begin : g_byp_in
      assign s1 = in_w;
    end
  endgenerate

  // X / Z muxes; Z=P closes the accumulate loop on the live register
  always_comb begin
    x = s1.xs ? {{(PW-MW){s1.m[MW-1]}}, s1.m} : '0;
    case (s1.zs)
      2'b01:   z = s1.pc;
      2'b10:   z = p_q;
      2'b11:   z = s1.c;
      default: z = '0;
    endcase
  end

  // unsigned PW+1 result; bit PW is the carry/borrow out
  always_comb begin
    if (s1.sb) r = {1'b0, z} - ({1'b0, x} + {{PW{1'b0}}, s1.ci});
    else       r = {1'b0, z} + {1'b0, x} + {{PW{1'b0}}, s1.ci};
  end

`ifdef DSP_SAT_EN
  // two guard bits hold the exact signed result; overflow when they disagree with the MSB
  logic [PW+1:0] full;
  logic          ov, ovf_q;

  always_comb begin
    if (s1.sb) full = {{2{z[PW-1]}}, z} - {{2{x[PW-1]}}, x} - {{(PW+1){1'b0}}, s1.ci};
    else       full = {{2{z[PW-1]}}, z} + {{2{x[PW-1]}}, x} + {{(PW+1){1'b0}}, s1.ci};
    ov = !((full[PW+1:PW-1] == 3'b000) || (full[PW+1:PW-1] == 3'b111));
    if (!ov)            p_nxt = r[PW-1:0];
    else if (full[PW+1]) p_nxt = {1'b1, {(PW-1){1'b0}}};
    else                p_nxt = {1'b0, {(PW-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)                 ovf_q <= 1'b0;
    else if (bus.en_p && ov)  ovf_q <= 1'b1;
  end

  assign bus.ovf = ovf_q;
`else
  assign p_nxt   = r[PW-1:0];
  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      p_q   <= '0;
      co_q  <= 1'b0;
      vld_q <= 1'b0;
    end else if (bus.en_p) begin
      p_q   <= p_nxt;
      co_q  <= r[PW];
      vld_q <= s1.vld;
    end else begin
      vld_q <= 1'b0;
    end
  end

  assign bus.p        = p_q;
  assign bus.pcout    = p_q;
  assign bus.carryout = co_q;
  assign bus.p_vld    = vld_q;

endmodule

// File: tb/tb_dsp_post_acc.sv
module tb_dsp_post_acc;
  localparam int PW = 48;
  localparam int MW = 36;
  localparam longint MASK = (64'sd1 <<< PW) - 1;
  localparam longint SMAX = (64'sd1 <<< (PW-1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (PW-1));

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dsp_post_acc_if #(.PW(PW), .MW(MW)) bus();
  dsp_post_acc #(.PW(PW), .MW(MW), .REG_IN(1)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic [MW-1:0] m;
    logic [PW-1:0] c, pc;
    logic          xs;
    logic [1:0]    zs;
    logic          sb, ci, vld;
  } op_t;

  int n_vec = 0, n_err = 0;
  op_t st;
  logic [PW-1:0] e_p;
  logic e_c, e_v, e_o;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".p"}, 64'(bus.p), 64'(e_p));
    chk({tag, ".pcout"}, 64'(bus.pcout), 64'(e_p));
    chk({tag, ".co"}, 64'(bus.carryout), 64'(e_c));
    chk({tag, ".vld"}, 64'(bus.p_vld), 64'(e_v));
    chk({tag, ".ovf"}, 64'(bus.ovf), 64'(e_o));
  endtask

  task automatic mdl_rst();
    e_p = '0; e_c = 0; e_v = 0; e_o = 0;
    st = '{m: '0, c: '0, pc: '0, xs: 0, zs: 2'b00, sb: 0, ci: 0, vld: 0};
  endtask

  // reference: exact integer arithmetic on the registered operation
  task automatic apply(input op_t o);
    longint zu, xs, xu, ur, full;
    case (o.zs)
      2'b01:   zu = longint'(o.pc);
      2'b10:   zu = longint'(e_p);
      2'b11:   zu = longint'(o.c);
      default: zu = 0;
    endcase
    xs = o.xs ? longint'($signed(o.m)) : 64'sd0;
    xu = xs & MASK;
    ur = o.sb ? zu - (xu + longint'(o.ci)) : zu + xu + longint'(o.ci);
    full = (zu > SMAX) ? zu - (MASK + 1) : zu;
    full = o.sb ? full - (xs + longint'(o.ci)) : full + xs + longint'(o.ci);
    e_c = ur[PW];
    e_p = ur[PW-1:0];
`ifdef DSP_SAT_EN
    if (full > SMAX) begin e_p = SMAX[PW-1:0]; e_o = 1; end
    if (full < SMIN) begin e_p = SMIN[PW-1:0]; e_o = 1; end
`endif
    e_v = o.vld;
  endtask

  task automatic mdl_edge();
    op_t cur;
    cur = '{m: bus.m_in, c: bus.c_in, pc: bus.pcin, xs: bus.x_sel, zs: bus.z_sel,
            sb: bus.sub, ci: bus.cin, vld: bus.in_vld};
    if (bus.en_p) begin
      apply(st);
      st = cur;
    end else e_v = 0;
  endtask

  task automatic set_op(input logic [MW-1:0] m, input logic [PW-1:0] c, input logic [PW-1:0] pc,
                        input logic xs, input logic [1:0] zs, input logic sb, input logic ci,
                        input logic vld, input logic en);
    bus.m_in = m; bus.c_in = c; bus.pcin = pc; bus.x_sel = xs; bus.z_sel = zs;
    bus.sub = sb; bus.cin = ci; bus.in_vld = vld; bus.en_p = en;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    mdl_edge();
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [63:0] r1, r2;
    rstn = 1'b1;
    set_op('0, '0, '0, 0, 2'b00, 0, 0, 0, 1);
    mdl_rst();
    #12;
    chk_all("rst0");
    @(negedge clk); rstn = 1'b0;

    // accumulate 5 per cycle, hold 3 cycles at 10, resume
    set_op(5, '0, '0, 1, 2'b10, 0, 0, 1, 1);
    tick("acc_fill");
    chk("acc_fill_vld", 64'(bus.p_vld), 0);
    tick("acc1"); chk("acc_5", 64'(bus.p), 5); chk("acc_5_vld", 64'(bus.p_vld), 1);
    tick("acc2"); chk("acc_10", 64'(bus.p), 10);
    bus.en_p = 0;
    for (int i = 0; i < 3; i++) begin
      tick("hold");
      chk("hold_p", 64'(bus.p), 10);
      chk("hold_vld", 64'(bus.p_vld), 0);
    end
    bus.en_p = 1;
    tick("acc3"); chk("acc_15", 64'(bus.p), 15);
    tick("acc4"); chk("acc_20", 64'(bus.p), 20); chk("acc_20_vld", 64'(bus.p_vld), 1);

    // async reset between edges at p=20
    #3 rstn = 1'b1;
    #1 mdl_rst();
    chk_all("rst_mid");
    chk("rst_mid_p", 64'(bus.p), 0);
    #2 rstn = 1'b0;
    tick("post_rst0"); chk("post_rst0_vld", 64'(bus.p_vld), 0);
    tick("post_rst1"); chk("post_rst_5", 64'(bus.p), 5); chk("post_rst_vld", 64'(bus.p_vld), 1);

    // subtract with carry
    set_op(30, 100, '0, 1, 2'b11, 1, 1, 1, 1);
    tick("sub_a0");
    tick("sub_a1"); chk("sub_69", 64'(bus.p), 69); chk("sub_69_co", 64'(bus.carryout), 0);
    set_op(1, 0, '0, 1, 2'b11, 1, 0, 1, 1);
    tick("sub_b0");
    tick("sub_b1");
    chk("sub_neg1", 64'(bus.p), 64'h0000_FFFF_FFFF_FFFF);
    chk("sub_neg1_co", 64'(bus.carryout), 1);

    // overflow from the most positive value
    set_op(0, 48'h7FFF_FFFF_FFFF, '0, 0, 2'b11, 0, 0, 1, 1);
    tick("ovf_ld0");
    set_op(1, '0, '0, 1, 2'b10, 0, 0, 1, 1);
    tick("ovf_ld1"); chk("ovf_max", 64'(bus.p), 64'h0000_7FFF_FFFF_FFFF);
    tick("ovf_step");
`ifdef DSP_SAT_EN
    chk("ovf_sat_p", 64'(bus.p), 64'h0000_7FFF_FFFF_FFFF);
    chk("ovf_sat_flag", 64'(bus.ovf), 1);
`else
    chk("ovf_wrap_p", 64'(bus.p), 64'h0000_8000_0000_0000);
    chk("ovf_wrap_flag", 64'(bus.ovf), 0);
`endif
    tick("ovf_step2");

    // randomized traffic against the model
    #3 rstn = 1'b1;
    #1 mdl_rst();
    #2 rstn = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      set_op(r1[MW-1:0], r2[PW-1:0], {r1[15:0], r2[63:32]}, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 3) == 0) bus.m_in = MW'($urandom_range(0, 7));
      tick("rnd");
      if ($urandom_range(0, 99) == 0) begin
        #3 rstn = 1'b1;
        #1 mdl_rst();
        chk_all("rnd_rst");
        #2 rstn = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
